// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage register and its skid buffer.
// The optional skid buffer is enabled by defining PIPE_SKID_EN.
package pipe_pkg;

  // Occupancy of the two-entry skid configuration.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  // Width of the per-flush drop amount (0..2 entries can be squashed at once).
  localparam int unsigned DROP_W = 2;

endpackage : pipe_pkg

// File: rtl/pipe_skid_buf.sv
// Skid entry plus occupancy FSM for the stage register (PIPE_SKID_EN builds only).
// Tells the top when and from where to load its main register; in_ready is registered
// so there is no combinational path from out_ready to in_ready.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned          WIDTH     = 32,
  parameter logic [WIDTH-1:0]     FLUSH_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             out_ready_i,
  output logic             in_ready_o,
  output logic             skid_valid_o,
  output logic [WIDTH-1:0] skid_data_o,
  output logic             main_load_o,
  output logic             main_src_skid_o,
  output logic             main_clear_o
);

  skid_state_e      state_q;
  logic             ready_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;

  assign accept       = in_valid_i & ready_q;
  assign in_ready_o   = ready_q;
  assign skid_valid_o = (state_q == FULL);
  assign skid_data_o  = skid_q;

  // Decide how the main register in the top moves this cycle.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    main_load_o     = 1'b0;
    main_src_skid_o = 1'b0;
    main_clear_o    = 1'b0;
    unique case (state_q)
      EMPTY: main_load_o = accept;
      BUSY: begin
        if (accept && out_ready_i)       main_load_o  = 1'b1;
        else if (!accept && out_ready_i) main_clear_o = 1'b1;
      end
      FULL: begin
        main_load_o     = out_ready_i;
        main_src_skid_o = out_ready_i;
      end
      default: ;
    endcase
  end

  // Occupancy FSM with registered in_ready and the skid payload.
  always_ff @(posedge clk_i) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst_i || flush_i) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
      skid_q  <= FLUSH_VAL;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) state_q <= BUSY;
        BUSY: begin
          if (accept && !out_ready_i) begin
            state_q <= FULL;
            ready_q <= 1'b0;
            skid_q  <= in_data_i;
          end else if (!accept && out_ready_i) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (out_ready_i) begin
            state_q <= BUSY;
            ready_q <= 1'b1;
            skid_q  <= FLUSH_VAL;
          end
        end
        default: begin
          state_q <= EMPTY;
          ready_q <= 1'b1;
          skid_q  <= FLUSH_VAL;
        end
      endcase
    end
  end

endmodule : pipe_skid_buf

// File: rtl/pipe_stage_reg.sv
// Parametrised pipeline stage register with valid/ready handshake, flush, bubble
// insertion and a saturating flush-drop counter. Define PIPE_SKID_EN for a two-entry
// skid buffer with registered in_ready; otherwise a single entry with comb in_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter int unsigned      CNT_W     = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] drop_cnt
);

  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W:0]    cnt_sum;
  logic [DROP_W-1:0] held;
  logic              main_load, main_src_skid, main_clear;
  logic [WIDTH-1:0]  skid_data;

`ifdef PIPE_SKID_EN
  logic skid_valid;

  pipe_skid_buf #(
    .WIDTH     (WIDTH),
    .FLUSH_VAL (FLUSH_VAL)
  ) u_skid (
    .clk_i           (CLK),
    .rst_i           (Reset),
    .flush_i         (flush),
    .in_valid_i      (in_valid),
    .in_data_i       (in_data),
    .out_ready_i     (out_ready),
    .in_ready_o      (in_ready),
    .skid_valid_o    (skid_valid),
    .skid_data_o     (skid_data),
    .main_load_o     (main_load),
    .main_src_skid_o (main_src_skid),
    .main_clear_o    (main_clear)
  );

  assign held = {1'b0, valid_q} + {1'b0, skid_valid};
`else
  assign in_ready      = out_ready | ~valid_q;
  assign main_load     = in_valid & in_ready;
  assign main_clear    = valid_q & out_ready & ~main_load;
  assign main_src_skid = 1'b0;
  assign skid_data     = FLUSH_VAL;
  assign held          = {1'b0, valid_q};
`endif

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign drop_cnt  = cnt_q;

  // Next main-register contents: load, bubble on drain, or hold on stall.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (main_load) begin
      valid_d = 1'b1;
      data_d  = main_src_skid ? skid_data : in_data;
    end else if (main_clear) begin
      valid_d = 1'b0;
      data_d  = FLUSH_VAL;
    end
  end

  // Drop counter increment by the entries squashed, clamped at all-ones.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + (CNT_W + 1)'(held);
    if (cnt_sum > {1'b0, {CNT_W{1'b1}}}) cnt_d = {CNT_W{1'b1}};
    else                                 cnt_d = cnt_sum[CNT_W-1:0];
  end

  // Main register and drop counter; reset beats flush, flush beats normal flow.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      valid_q <= 1'b0;
      data_q  <= FLUSH_VAL;
      cnt_q   <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
      data_q  <= FLUSH_VAL;
      cnt_q   <= cnt_d;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule : pipe_stage_reg

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic,
// all checked against a queue-based model of the stage. Two instances share stimulus:
// one with the default 8-bit drop counter and one with a 2-bit counter for saturation.
module tb_pipe_stage_reg;

`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        Reset, in_valid, flush, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [7:0]  drop_cnt;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_out_data;
  logic [1:0]  s_drop_cnt;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Reference model: FIFO of held payloads and an unsaturated drop total.
  logic [31:0] q[$];
  int          raw_drops = 0;

  pipe_stage_reg #(.WIDTH(32), .FLUSH_VAL(32'h0), .CNT_W(8)) u_dut (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .drop_cnt(drop_cnt)
  );

  pipe_stage_reg #(.WIDTH(32), .FLUSH_VAL(32'h0), .CNT_W(2)) u_sat (
    .CLK(CLK), .Reset(Reset), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
    .drop_cnt(s_drop_cnt)
  );

  always #5 CLK = ~CLK;

  function automatic bit mdl_in_ready();
    if (SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic logic [31:0] mdl_data();
    return (q.size() > 0) ? q[0] : 32'h0;
  endfunction

  function automatic int sat(input int raw, input int maxv);
    return (raw > maxv) ? maxv : raw;
  endfunction

  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [31:0] d, input logic o);
    Reset = r; flush = f; in_valid = v; in_data = d; out_ready = o;
    #1;
  endtask

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic cycle();
    bit acc;
    if (Reset) begin
      q.delete();
      raw_drops = 0;
    end else if (flush) begin
      raw_drops += q.size();
      q.delete();
    end else begin
      acc = in_valid && mdl_in_ready();
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) q.push_back(in_data);
    end
    @(posedge CLK);
    #2;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 32'h0, 1);
    cycle();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", out_valid); else pass_cnt++;
    total_cnt++; if (out_data !== 32'h0) $display("FAIL reset_data got=%h exp=0", out_data); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop got=%0d exp=0", drop_cnt); else pass_cnt++;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    drive(0, 0, 1, 32'hDEADBEEF, 0);
    cycle();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'hDEADBEEF)
      $display("FAIL midstream_load got=%b/%h exp=1/deadbeef", out_valid, out_data); else pass_cnt++;
    drive(1, 0, 0, 32'h0, 0);
    cycle();
    total_cnt++; if (out_valid !== 1'b0 || out_data !== 32'h0)
      $display("FAIL midstream_reset got=%b/%h exp=0/0", out_valid, out_data); else pass_cnt++;
    total_cnt++; if (drop_cnt !== 8'd0 || in_ready !== 1'b1)
      $display("FAIL midstream_reset_drop_rdy got=%0d/%b exp=0/1", drop_cnt, in_ready); else pass_cnt++;
  endtask

  task automatic test_stream();
    logic [31:0] vals [3] = '{32'h1, 32'h2, 32'h3};
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, vals[i], 1);
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d] got=%b exp=1", i, in_ready); else pass_cnt++;
      cycle();
      total_cnt++; if (out_valid !== 1'b1 || out_data !== vals[i])
        $display("FAIL stream_out[%0d] got=%b/%h exp=1/%h", i, out_valid, out_data, vals[i]); else pass_cnt++;
    end
    drive(0, 0, 0, 32'h0, 1);
    cycle();
    total_cnt++; if (out_valid !== 1'b0 || out_data !== 32'h0)
      $display("FAIL stream_bubble got=%b/%h exp=0/0", out_valid, out_data); else pass_cnt++;
  endtask

  task automatic test_stall();
    drive(0, 0, 1, 32'h5, 0);
    cycle();
    drive(0, 0, 1, 32'h6, 0);
    total_cnt++; if (in_ready !== SKID) $display("FAIL stall_first_in_ready got=%b exp=%b", in_ready, SKID); else pass_cnt++;
    cycle();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, !SKID, 32'h6, 0);
      total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'h5 || in_ready !== 1'b0)
        $display("FAIL stall_hold[%0d] got=%b/%h/rdy%b exp=1/5/rdy0", i, out_valid, out_data, in_ready); else pass_cnt++;
      cycle();
    end
    drive(0, 0, !SKID, 32'h6, 1);
    total_cnt++; if (out_data !== 32'h5) $display("FAIL stall_release_first got=%h exp=5", out_data); else pass_cnt++;
    cycle();
    total_cnt++; if (out_valid !== 1'b1 || out_data !== 32'h6)
      $display("FAIL stall_release_second got=%b/%h exp=1/6", out_valid, out_data); else pass_cnt++;
    drive(0, 0, 0, 32'h0, 1);
    cycle();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL stall_drain got=%b exp=0", out_valid); else pass_cnt++;
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 32'h0, 1);
    cycle();
    drive(0, 0, 1, 32'h9, 0);
    cycle();
    drive(0, 1, 1, 32'h7, 1);
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got=%b exp=1", in_ready); else pass_cnt++;
    cycle();
    total_cnt++; if (out_valid !== 1'b0 || out_data !== 32'h0 || drop_cnt !== 8'd1)
      $display("FAIL flush_one got=%b/%h/%0d exp=0/0/1", out_valid, out_data, drop_cnt); else pass_cnt++;
    drive(0, 0, 0, 32'h0, 1);
    cycle();
    total_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_not_captured got=%b exp=0", out_valid); else pass_cnt++;
`ifdef PIPE_SKID_EN
    drive(0, 0, 1, 32'hA, 0);
    cycle();
    drive(0, 0, 1, 32'hB, 0);
    cycle();
    drive(0, 1, 0, 32'h0, 0);
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_full_in_ready got=%b exp=0", in_ready); else pass_cnt++;
    cycle();
    total_cnt++; if (out_valid !== 1'b0 || drop_cnt !== 8'd3)
      $display("FAIL flush_full got=%b/%0d exp=0/3", out_valid, drop_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_saturation();
    drive(1, 0, 0, 32'h0, 0);
    cycle();
    for (int k = 1; k <= 5; k++) begin
      drive(0, 0, 1, 32'(k), 0);
      cycle();
      drive(0, 1, 0, 32'h0, 0);
      cycle();
      total_cnt++; if (s_drop_cnt !== 2'(sat(k, 3)))
        $display("FAIL sat_drop[%0d] got=%0d exp=%0d", k, s_drop_cnt, sat(k, 3)); else pass_cnt++;
      total_cnt++; if (drop_cnt !== 8'(k))
        $display("FAIL wide_drop[%0d] got=%0d exp=%0d", k, drop_cnt, k); else pass_cnt++;
    end
  endtask

  task automatic test_flush_empty_reset();
    drive(0, 1, 0, 32'h0, 0);
    cycle();
    total_cnt++; if (drop_cnt !== 8'd5 || s_drop_cnt !== 2'd3)
      $display("FAIL flush_empty got=%0d/%0d exp=5/3", drop_cnt, s_drop_cnt); else pass_cnt++;
    drive(0, 0, 1, 32'h11, 0);
    cycle();
    drive(1, 1, 0, 32'h0, 0);
    cycle();
    total_cnt++; if (drop_cnt !== 8'd0 || s_drop_cnt !== 2'd0 || out_valid !== 1'b0)
      $display("FAIL reset_flush got=%0d/%0d/%b exp=0/0/0", drop_cnt, s_drop_cnt, out_valid); else pass_cnt++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
            $urandom, $urandom_range(0, 9) < 6);
      total_cnt++; if (in_ready !== mdl_in_ready())
        $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, in_ready, mdl_in_ready()); else pass_cnt++;
      cycle();
      total_cnt++; if (out_valid !== (q.size() > 0) || out_data !== mdl_data())
        $display("FAIL rnd_out[%0d] got=%b/%h exp=%b/%h", i, out_valid, out_data, q.size() > 0, mdl_data()); else pass_cnt++;
      total_cnt++; if (drop_cnt !== 8'(sat(raw_drops, 255)) || s_drop_cnt !== 2'(sat(raw_drops, 3)))
        $display("FAIL rnd_drop[%0d] got=%0d/%0d exp=%0d/%0d", i, drop_cnt, s_drop_cnt,
                 sat(raw_drops, 255), sat(raw_drops, 3)); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_saturation();
    test_flush_empty_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_pipe_stage_reg
